// File: rtl/tmplt_pkg.sv
// Shared definitions for the Time Pilot ROM loader and the core's ROM
// instantiations.
//   - state_t        : loader FSM states
//   - RGN_*          : bit index of each ROM region in the one-hot write enable
//   - DEF_*_BASE/SIZE: default image layout (byte addresses / sizes)
package tmplt_pkg;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_LOAD,
        ST_HOLD,
        ST_RUN
    } state_t;

    localparam int NUM_RGN  = 5;
    localparam int RGN_CPU  = 0;
    localparam int RGN_SND  = 1;
    localparam int RGN_CHR  = 2;
    localparam int RGN_SPR  = 3;
    localparam int RGN_PROM = 4;

    localparam logic [15:0] DEF_SND_BASE  = 16'h6000;
    localparam logic [15:0] DEF_CHR_BASE  = 16'h7000;
    localparam logic [15:0] DEF_SPR_BASE  = 16'h9000;
    localparam logic [15:0] DEF_PROM_BASE = 16'hD000;
    localparam logic [15:0] DEF_TOTAL     = 16'hD240;
    localparam int          DEF_HOLD_CYCLES = 1024;

    localparam logic [15:0] DEF_CPU_SIZE  = DEF_SND_BASE;
    localparam logic [15:0] DEF_SND_SIZE  = DEF_CHR_BASE - DEF_SND_BASE;
    localparam logic [15:0] DEF_CHR_SIZE  = DEF_SPR_BASE - DEF_CHR_BASE;
    localparam logic [15:0] DEF_SPR_SIZE  = DEF_PROM_BASE - DEF_SPR_BASE;
    localparam logic [15:0] DEF_PROM_SIZE = DEF_TOTAL - DEF_PROM_BASE;

endpackage

// File: rtl/tmplt_rgn_decode.sv
// Combinational ROM region decoder.
// Ports:
//   addr   in  25 : ioctl byte address
//   valid  out 1  : address lies inside the image (upper bits clear, < TOTAL)
//   rgn    out 5  : one-hot region {prom, spr, chr, snd, cpu}; 0 when invalid
//   offset out 16 : address relative to the region base; 0 when invalid
module tmplt_rgn_decode
    import tmplt_pkg::*;
#(
    parameter logic [15:0] SND_BASE  = DEF_SND_BASE,
    parameter logic [15:0] CHR_BASE  = DEF_CHR_BASE,
    parameter logic [15:0] SPR_BASE  = DEF_SPR_BASE,
    parameter logic [15:0] PROM_BASE = DEF_PROM_BASE,
    parameter logic [15:0] TOTAL     = DEF_TOTAL
) (
    input  logic [24:0]        addr,
    output logic               valid,
    output logic [NUM_RGN-1:0] rgn,
    output logic [15:0]        offset
);

    logic [15:0] lo;
    assign lo = addr[15:0];

    always_comb begin
        valid  = (addr[24:16] == 9'd0) && (lo < TOTAL);
        rgn    = '0;
        offset = '0;
        if (valid) begin
            // Highest base not above the address wins.
            if (lo >= PROM_BASE) begin
                rgn[RGN_PROM] = 1'b1;
                offset        = lo - PROM_BASE;
            end else if (lo >= SPR_BASE) begin
                rgn[RGN_SPR] = 1'b1;
                offset       = lo - SPR_BASE;
            end else if (lo >= CHR_BASE) begin
                rgn[RGN_CHR] = 1'b1;
                offset       = lo - CHR_BASE;
            end else if (lo >= SND_BASE) begin
                rgn[RGN_SND] = 1'b1;
                offset       = lo - SND_BASE;
            end else begin
                rgn[RGN_CPU] = 1'b1;
                offset       = lo;
            end
        end
    end

endmodule

// File: rtl/tmplt_rom_loader.sv
// ROM download router and core reset sequencer for the Time Pilot core.
// Routes each ioctl byte to one of five ROM regions, counts strobes, and only
// releases the core from reset after a complete, in-range image plus a fixed
// settle hold.
// Ports:
//   clk_sys        in  1  : system clock
//   reset          in  1  : synchronous active-high reset
//   ioctl_download in  1  : download active
//   ioctl_wr       in  1  : one-cycle byte strobe
//   ioctl_addr     in  25 : byte address
//   ioctl_dout     in  8  : byte data
//   dn_addr        out 16 : region-relative address (registered)
//   dn_data        out 8  : byte data (registered)
//   dn_we          out 5  : one-hot write enable {prom, spr, chr, snd, cpu}
//   core_reset     out 1  : core held in reset unless running
//   load_done      out 1  : image loaded and hold expired
//   load_err       out 1  : last download short or contained out-of-range bytes
module tmplt_rom_loader
    import tmplt_pkg::*;
#(
    parameter logic [15:0] SND_BASE    = DEF_SND_BASE,
    parameter logic [15:0] CHR_BASE    = DEF_CHR_BASE,
    parameter logic [15:0] SPR_BASE    = DEF_SPR_BASE,
    parameter logic [15:0] PROM_BASE   = DEF_PROM_BASE,
    parameter logic [15:0] TOTAL       = DEF_TOTAL,
    parameter int          HOLD_CYCLES = DEF_HOLD_CYCLES
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic               ioctl_download,
    input  logic               ioctl_wr,
    input  logic [24:0]        ioctl_addr,
    input  logic [7:0]         ioctl_dout,
    output logic [15:0]        dn_addr,
    output logic [7:0]         dn_data,
    output logic [NUM_RGN-1:0] dn_we,
    output logic               core_reset,
    output logic               load_done,
    output logic               load_err
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    state_t             state, state_nxt;
    logic [15:0]        cnt, cnt_upd;
    logic               over, over_upd;
    logic [HW-1:0]      hold_cnt;
    logic               wr_ok, wr_bad, enter_load;
    logic               dec_valid;
    logic [NUM_RGN-1:0] dec_rgn;
    logic [15:0]        dec_off;

    tmplt_rgn_decode #(
        .SND_BASE  (SND_BASE),
        .CHR_BASE  (CHR_BASE),
        .SPR_BASE  (SPR_BASE),
        .PROM_BASE (PROM_BASE),
        .TOTAL     (TOTAL)
    ) u_decode (
        .addr   (ioctl_addr),
        .valid  (dec_valid),
        .rgn    (dec_rgn),
        .offset (dec_off)
    );

    always_ff @(posedge clk_sys) begin
        if (reset) state <= ST_BOOT;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        wr_ok      = (state == ST_LOAD) && ioctl_wr && dec_valid;
        wr_bad     = (state == ST_LOAD) && ioctl_wr && !dec_valid;
        // A strobe arriving with the falling download is counted before the
        // completeness check, so the check looks at the updated values.
        cnt_upd    = (wr_ok && cnt != 16'hFFFF) ? cnt + 16'd1 : cnt;
        over_upd   = over | wr_bad;
        case (state)
            ST_BOOT: if (ioctl_download) state_nxt = ST_LOAD;
            ST_LOAD: begin
                if (!ioctl_download) begin
                    if (cnt_upd >= TOTAL && !over_upd) state_nxt = ST_HOLD;
                    else                                state_nxt = ST_BOOT;
                end
            end
            ST_HOLD: begin
                if (ioctl_download)       state_nxt = ST_LOAD;
                else if (hold_cnt == '0)  state_nxt = ST_RUN;
            end
            ST_RUN:  if (ioctl_download) state_nxt = ST_LOAD;
            default: state_nxt = ST_BOOT;
        endcase
        enter_load = (state != ST_LOAD) && (state_nxt == ST_LOAD);
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cnt      <= '0;
            over     <= 1'b0;
            load_err <= 1'b0;
            hold_cnt <= '0;
            dn_we    <= '0;
            dn_addr  <= '0;
            dn_data  <= '0;
        end else begin
            dn_we <= wr_ok ? dec_rgn : '0;
            if (wr_ok) begin
                dn_addr <= dec_off;
                dn_data <= ioctl_dout;
            end

            if (enter_load) begin
                cnt      <= '0;
                over     <= 1'b0;
                load_err <= 1'b0;
            end else if (state == ST_LOAD) begin
                cnt  <= cnt_upd;
                over <= over_upd;
                if (state_nxt == ST_BOOT) load_err <= 1'b1;
            end

            if (state == ST_LOAD && state_nxt == ST_HOLD)
                hold_cnt <= HW'(HOLD_CYCLES - 1);
            else if (state == ST_HOLD && hold_cnt != '0)
                hold_cnt <= hold_cnt - HW'(1);
        end
    end

    // Reset gating keeps the core parked for the whole reset pulse, even when
    // the FSM was in RUN when reset arrived.
    assign core_reset = reset | (state != ST_RUN);
    assign load_done  = ~reset & (state == ST_RUN);

endmodule

// File: tb/tb_tmplt_rom_loader.sv
// Directed bench for tmplt_rom_loader. The loader runs with a scaled-down
// image layout (same shape, 216 bytes) so several complete loads fit in a
// short run; a separate decoder instance keeps the production layout and is
// checked on the real region edges.
module tb_tmplt_rom_loader;
    import tmplt_pkg::*;

    localparam logic [15:0] B_SND  = 16'h0060;
    localparam logic [15:0] B_CHR  = 16'h0070;
    localparam logic [15:0] B_SPR  = 16'h0090;
    localparam logic [15:0] B_PROM = 16'h00D0;
    localparam logic [15:0] B_TOT  = 16'h00D8;
    localparam int          HOLD   = 1024;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [15:0] dn_addr;
    logic [7:0]  dn_data;
    logic [4:0]  dn_we;
    logic        core_reset;
    logic        load_done;
    logic        load_err;

    logic [24:0] dec_addr;
    logic        dec_valid;
    logic [4:0]  dec_rgn;
    logic [15:0] dec_off;

    int nchk = 0;
    int nerr = 0;

    always #5 clk_sys = ~clk_sys;

    tmplt_rom_loader #(
        .SND_BASE    (B_SND),
        .CHR_BASE    (B_CHR),
        .SPR_BASE    (B_SPR),
        .PROM_BASE   (B_PROM),
        .TOTAL       (B_TOT),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .dn_addr        (dn_addr),
        .dn_data        (dn_data),
        .dn_we          (dn_we),
        .core_reset     (core_reset),
        .load_done      (load_done),
        .load_err       (load_err)
    );

    tmplt_rgn_decode u_dec_full (
        .addr   (dec_addr),
        .valid  (dec_valid),
        .rgn    (dec_rgn),
        .offset (dec_off)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference region map of the scaled layout.
    function automatic logic [4:0] m_we(input logic [15:0] a);
        if (a >= B_PROM)     return 5'b10000;
        else if (a >= B_SPR) return 5'b01000;
        else if (a >= B_CHR) return 5'b00100;
        else if (a >= B_SND) return 5'b00010;
        else                 return 5'b00001;
    endfunction

    function automatic logic [15:0] m_off(input logic [15:0] a);
        if (a >= B_PROM)     return a - B_PROM;
        else if (a >= B_SPR) return a - B_SPR;
        else if (a >= B_CHR) return a - B_CHR;
        else if (a >= B_SND) return a - B_SND;
        else                 return a;
    endfunction

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Back-to-back strobes first..first+n-1, data = addr[7:0]; optionally
    // drops download together with the final strobe.
    task automatic stream(input logic [24:0] first, input int n, input bit drop_last);
        logic [24:0] a;
        for (int i = 0; i < n; i++) begin
            a          = first + 25'(i);
            ioctl_addr = a;
            ioctl_dout = a[7:0];
            ioctl_wr   = 1'b1;
            if (drop_last && i == n - 1) ioctl_download = 1'b0;
            tick();
            check($sformatf("wr_%0h", a), {3'b0, dn_we, dn_addr, dn_data},
                  {3'b0, m_we(a[15:0]), m_off(a[15:0]), a[7:0]});
        end
        ioctl_wr = 1'b0;
    endtask

    task automatic strobe(input logic [24:0] a, input logic [7:0] d);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr   = 1'b0;
    endtask

    task automatic wait_run(input string tag);
        int k = 0;
        while (core_reset && k < 3000) begin
            tick();
            k++;
        end
        check(tag, k, HOLD);
    endtask

    task automatic start_load();
        ioctl_download = 1'b1;
        tick();
    endtask

    logic [24:0] edge_a  [8];
    logic [20:0] edge_e  [8];
    logic [24:0] full_a  [10];
    logic [21:0] full_e  [10];

    initial begin
        edge_a = '{25'h005F, 25'h0060, 25'h006F, 25'h0070, 25'h0095, 25'h00CF, 25'h00D0, 25'h00D7};
        edge_e = '{{5'b00001, 16'h005F}, {5'b00010, 16'h0000}, {5'b00010, 16'h000F},
                   {5'b00100, 16'h0000}, {5'b01000, 16'h0005}, {5'b01000, 16'h003F},
                   {5'b10000, 16'h0000}, {5'b10000, 16'h0007}};
        full_a = '{25'h05FFF, 25'h06000, 25'h06FFF, 25'h07000, 25'h09005,
                   25'h0CFFF, 25'h0D000, 25'h0D23F, 25'h0D240, 25'h10000};
        full_e = '{{1'b1, 5'b00001, 16'h5FFF}, {1'b1, 5'b00010, 16'h0000},
                   {1'b1, 5'b00010, 16'h0FFF}, {1'b1, 5'b00100, 16'h0000},
                   {1'b1, 5'b01000, 16'h0005}, {1'b1, 5'b01000, 16'h3FFF},
                   {1'b1, 5'b10000, 16'h0000}, {1'b1, 5'b10000, 16'h023F},
                   {1'b0, 5'b00000, 16'h0000}, {1'b0, 5'b00000, 16'h0000}};

        reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0;
        ioctl_addr = '0; ioctl_dout = '0; dec_addr = '0;

        // Production-layout decoder on the real region edges.
        for (int i = 0; i < 10; i++) begin
            dec_addr = full_a[i];
            #1;
            check($sformatf("dec_%0h", full_a[i]), {10'b0, dec_valid, dec_rgn, dec_off},
                  {10'b0, full_e[i]});
        end

        // Reset state.
        tick(); tick();
        check("rst_we", dn_we, 0);
        check("rst_addr", dn_addr, 0);
        check("rst_data", dn_data, 0);
        check("rst_core_reset", core_reset, 1);
        check("rst_done", load_done, 0);
        check("rst_err", load_err, 0);
        reset = 1'b0;
        tick();
        check("boot_core_reset", core_reset, 1);

        // Full load, download dropping with the final strobe.
        start_load();
        stream(25'h0, int'(B_TOT), 1'b1);
        check("full_hold_core_reset", core_reset, 1);
        wait_run("full_hold_len");
        check("full_done", load_done, 1);
        check("full_err", load_err, 0);

        // Reload from RUN, with region-edge strobes, then a full image.
        start_load();
        check("reload_core_reset", core_reset, 1);
        check("reload_done", load_done, 0);
        for (int i = 0; i < 8; i++) begin
            strobe(edge_a[i], 8'hA5);
            check($sformatf("edge_%0h", edge_a[i]), {11'b0, dn_we, dn_addr}, {11'b0, edge_e[i]});
            check($sformatf("edge_data_%0h", edge_a[i]), dn_data, 8'hA5);
        end
        stream(25'h0, int'(B_TOT), 1'b1);
        wait_run("reload_hold_len");
        check("reload_done_end", load_done, 1);

        // Short load: one byte missing.
        start_load();
        stream(25'h0, int'(B_TOT) - 1, 1'b1);
        check("short_err", load_err, 1);
        check("short_core_reset", core_reset, 1);
        check("short_done", load_done, 0);
        repeat (HOLD + 50) tick();
        check("short_core_reset_late", core_reset, 1);

        // Out-of-range strobes on top of a full image.
        start_load();
        check("oor_err_cleared", load_err, 0);
        stream(25'h0, int'(B_TOT), 1'b0);
        strobe({9'b0, B_TOT}, 8'h11);
        check("oor_we_total", dn_we, 0);
        strobe(25'h10000, 8'h22);
        check("oor_we_high", dn_we, 0);
        ioctl_download = 1'b0;
        tick();
        check("oor_err", load_err, 1);
        repeat (HOLD + 50) tick();
        check("oor_core_reset", core_reset, 1);
        check("oor_done", load_done, 0);

        // Abort: reset with a write in flight; counter must restart at 0,
        // so a following one-byte-short image is rejected.
        start_load();
        stream(25'h0, 64, 1'b0);
        strobe(25'h0041, 8'h41);
        check("abort_inflight_we", dn_we, 5'b00001);
        reset = 1'b1;
        tick();
        check("abort_we", dn_we, 0);
        check("abort_core_reset", core_reset, 1);
        reset = 1'b0;
        tick();
        stream(25'h0, int'(B_TOT) - 1, 1'b1);
        check("abort_cnt_restart_err", load_err, 1);
        check("abort_core_reset_end", core_reset, 1);

        // Final back-to-back image accepted.
        start_load();
        stream(25'h0, int'(B_TOT), 1'b1);
        wait_run("final_hold_len");
        check("final_done", load_done, 1);
        check("final_err", load_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
